// File: rtl/ifmap_output_fsm.sv
// Read-side controller for the ifmap double buffer: sweeps the read bank in
// conv-window order after each switch and streams words under valid/ready.
module ifmap_output_fsm #(
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int OX0             = 3,
  parameter int OY0             = 3,
  parameter int FX              = 3,
  parameter int FY              = 3,
  parameter int IC1             = 2,
  parameter int STRIDE          = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       switch,
  input  logic                       out_ready,
  output logic                       ren,
  output logic [BANK_ADDR_WIDTH-1:0] raddr,
  output logic                       out_valid,
  output logic                       reading_last,
  output logic                       ready_to_switch,
  output logic                       err_switch
);
  localparam int IX0  = (OX0-1)*STRIDE+FX;
  localparam int IY0  = (OY0-1)*STRIDE+FY;
  localparam int M0   = (OX0 > OY0) ? OX0 : OY0;
  localparam int M1   = (FX > FY) ? FX : FY;
  localparam int M2   = (M0 > M1) ? M0 : M1;
  localparam int MAXD = (M2 > IC1) ? M2 : IC1;
  localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int AW   = BANK_ADDR_WIDTH;

  typedef enum logic [1:0] {WAIT_SWITCH, READ, DRAIN} state_t;

  typedef struct packed {
    logic [CW-1:0] ic1;
    logic [CW-1:0] fy;
    logic [CW-1:0] fx;
    logic [CW-1:0] oy0;
    logic [CW-1:0] ox0;
  } cnt_t;

  state_t state, state_nxt;
  cnt_t   cnt, cnt_nxt;
  logic   ov_nxt, err_nxt;
  logic   l_ox, l_oy, l_fx, l_fy, l_ic, all_last;

  assign l_ox     = (cnt.ox0 == CW'(OX0-1));
  assign l_oy     = (cnt.oy0 == CW'(OY0-1));
  assign l_fx     = (cnt.fx  == CW'(FX-1));
  assign l_fy     = (cnt.fy  == CW'(FY-1));
  assign l_ic     = (cnt.ic1 == CW'(IC1-1));
  assign all_last = l_ox & l_oy & l_fx & l_fy & l_ic;

  // Window address: channel-block base + input row + input column.
  assign raddr = AW'(cnt.ic1) * AW'(IX0*IY0)
               + (AW'(cnt.oy0) * AW'(STRIDE) + AW'(cnt.fy)) * AW'(IX0)
               + AW'(cnt.ox0) * AW'(STRIDE) + AW'(cnt.fx);

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    ren             = 1'b0;
    ready_to_switch = 1'b0;
    case (state)
      WAIT_SWITCH: begin
        ready_to_switch = 1'b1;
        if (switch) begin
          state_nxt = READ;
          cnt_nxt   = '0;
        end
      end
      READ: begin
        // A word parked on the buffer output blocks the next read.
        ren = !out_valid || out_ready;
        if (ren) begin
          if (!l_ox) cnt_nxt.ox0 = cnt.ox0 + 1'b1;
          else begin
            cnt_nxt.ox0 = '0;
            if (!l_oy) cnt_nxt.oy0 = cnt.oy0 + 1'b1;
            else begin
              cnt_nxt.oy0 = '0;
              if (!l_fx) cnt_nxt.fx = cnt.fx + 1'b1;
              else begin
                cnt_nxt.fx = '0;
                if (!l_fy) cnt_nxt.fy = cnt.fy + 1'b1;
                else begin
                  cnt_nxt.fy = '0;
                  if (!l_ic) cnt_nxt.ic1 = cnt.ic1 + 1'b1;
                  else       cnt_nxt.ic1 = '0;
                end
              end
            end
          end
          if (all_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid || out_ready) state_nxt = WAIT_SWITCH;
      end
      default: state_nxt = WAIT_SWITCH;
    endcase
    reading_last = ren && all_last;
    if (ren)                         ov_nxt = 1'b1;
    else if (out_valid && out_ready) ov_nxt = 1'b0;
    else                             ov_nxt = out_valid;
    err_nxt = err_switch || (switch && (state != WAIT_SWITCH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_SWITCH;
      cnt        <= '0;
      out_valid  <= 1'b0;
      err_switch <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      out_valid  <= ov_nxt;
      err_switch <= err_nxt;
    end
  end
endmodule

// File: tb/tb_ifmap_output_fsm.sv
// Scoreboard bench: small 2x2x2x2 instance for sequence/backpressure/reset,
// default-parameter instance for the full 162-read sweep.
module tb_ifmap_output_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       switch_s = 1'b0, out_ready_s = 1'b0;
  logic       ren_s, out_valid_s, reading_last_s, rts_s, err_s;
  logic [7:0] raddr_s;
  logic       switch_d = 1'b0, out_ready_d = 1'b0;
  logic       ren_d, out_valid_d, reading_last_d, rts_d, err_d;
  logic [7:0] raddr_d;

  ifmap_output_fsm #(.BANK_ADDR_WIDTH(8), .OX0(2), .OY0(2), .FX(2), .FY(2), .IC1(1), .STRIDE(1)) dut (
    .clk(clk), .rst(rst), .switch(switch_s), .out_ready(out_ready_s),
    .ren(ren_s), .raddr(raddr_s), .out_valid(out_valid_s), .reading_last(reading_last_s),
    .ready_to_switch(rts_s), .err_switch(err_s));

  ifmap_output_fsm dut_def (
    .clk(clk), .rst(rst), .switch(switch_d), .out_ready(out_ready_d),
    .ren(ren_d), .raddr(raddr_d), .out_valid(out_valid_d), .reading_last(reading_last_d),
    .ready_to_switch(rts_d), .err_switch(err_d));

  int compared = 0, mismatched = 0;
  logic [7:0] tbl [16] = '{8'd0, 8'd1, 8'd3, 8'd4, 8'd1, 8'd2, 8'd4, 8'd5,
                           8'd3, 8'd4, 8'd6, 8'd7, 8'd4, 8'd5, 8'd7, 8'd8};
  logic [7:0] exp_q [$];
  logic [7:0] rdata_s = '0;
  int cyc, n_ren, n_acc, first_ren, last_ren, rise;

  task automatic sb_start();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(tbl[i]);
    cyc = 0; n_ren = 0; n_acc = 0; first_ren = -1; last_ren = -1; rise = -1;
  endtask

  // One cycle on the small DUT: drive at negedge, sample 1ns later, model buffer at posedge.
  task automatic cyc_s(input logic sw, input logic rdy);
    logic cap_en;
    logic [7:0] cap_a, e;
    switch_s = sw; out_ready_s = rdy;
    #1;
    if (ren_s) begin
      compared++;
      if (n_ren >= 16) begin
        mismatched++; $display("FAIL extra_read: read #%0d issued, bank holds only 16", n_ren);
      end else if (raddr_s !== tbl[n_ren]) begin
        mismatched++; $display("FAIL raddr[%0d]: got %0d expected %0d", n_ren, raddr_s, tbl[n_ren]);
      end
      compared++;
      if (reading_last_s !== (n_ren == 15)) begin
        mismatched++; $display("FAIL reading_last[%0d]: got %b expected %b", n_ren, reading_last_s, (n_ren == 15));
      end
      compared++;
      if (rts_s !== 1'b0) begin
        mismatched++; $display("FAIL rts_in_read[%0d]: got %b expected 0", n_ren, rts_s);
      end
      if (n_ren == 0) first_ren = cyc;
      last_ren = cyc;
      n_ren++;
    end
    if (out_valid_s && !rdy) begin
      compared++;
      if (ren_s !== 1'b0) begin
        mismatched++; $display("FAIL ren_stall: got %b expected 0 while out_valid&!out_ready", ren_s);
      end
    end
    if (out_valid_s && rdy) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++; $display("FAIL word_extra: got %0d expected no more words", rdata_s);
      end else begin
        e = exp_q.pop_front();
        if (rdata_s !== e) begin
          mismatched++; $display("FAIL word[%0d]: got %0d expected %0d", n_acc, rdata_s, e);
        end
      end
      n_acc++;
    end
    if (rts_s && n_ren == 16 && rise < 0) rise = cyc;
    cap_en = ren_s; cap_a = raddr_s;
    @(posedge clk);
    if (cap_en) rdata_s = cap_a;
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_bank_end(input string tag);
    compared++;
    if (n_ren !== 16) begin mismatched++; $display("FAIL %s_reads: got %0d expected 16", tag, n_ren); end
    compared++;
    if (n_acc !== 16 || exp_q.size() != 0) begin
      mismatched++; $display("FAIL %s_accepted: got %0d (left %0d) expected 16 (left 0)", tag, n_acc, exp_q.size());
    end
    compared++;
    if (rise < 0) begin mismatched++; $display("FAIL %s_rts_timeout: got no rise expected rise", tag); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      compared++;
      if ({ren_s, out_valid_s, rts_s, err_s, ren_d, out_valid_d, rts_d, err_d} !== 8'b0010_0010) begin
        mismatched++;
        $display("FAIL reset_state: got ren/ov/rts/err s=%b%b%b%b d=%b%b%b%b expected 0010 0010",
                 ren_s, out_valid_s, rts_s, err_s, ren_d, out_valid_d, rts_d, err_d);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    sb_start();
    cyc_s(1'b1, 1'b1);
    for (int i = 0; i < 60 && rise < 0; i++) cyc_s(1'b0, 1'b1);
    check_bank_end("basic");
    compared++;
    if (last_ren - first_ren !== 15) begin
      mismatched++; $display("FAIL basic_contiguous: got span %0d expected 15", last_ren - first_ren);
    end
    compared++;
    if (rise - last_ren !== 2) begin
      mismatched++; $display("FAIL basic_rts_delay: got %0d expected 2", rise - last_ren);
    end
  endtask

  task automatic test_backpressure();
    sb_start();
    cyc_s(1'b1, 1'b1);
    for (int i = 0; i < 200 && rise < 0; i++) cyc_s(1'b0, (cyc % 4 == 0) || (cyc % 4 == 3));
    check_bank_end("bp");
    compared++;
    if (out_valid_s !== 1'b0) begin mismatched++; $display("FAIL bp_ov_end: got %b expected 0", out_valid_s); end
  endtask

  task automatic test_switch_err();
    sb_start();
    compared++;
    if (err_s !== 1'b0) begin mismatched++; $display("FAIL err_pre: got %b expected 0", err_s); end
    cyc_s(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc_s(1'b0, 1'b1);
    cyc_s(1'b1, 1'b1);
    #1;
    compared++;
    if (err_s !== 1'b1) begin mismatched++; $display("FAIL err_set: got %b expected 1", err_s); end
    for (int i = 0; i < 60 && rise < 0; i++) cyc_s(1'b0, 1'b1);
    check_bank_end("err");
    compared++;
    if (err_s !== 1'b1) begin mismatched++; $display("FAIL err_sticky: got %b expected 1", err_s); end
  endtask

  task automatic test_default_params();
    int n = 0, nlast = 0;
    logic [7:0] last_a = '0;
    bit done = 0;
    switch_d = 1'b1; out_ready_d = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      #1;
      if (ren_d) begin
        n++;
        if (reading_last_d) begin nlast++; last_a = raddr_d; end
      end
      if (rts_d && n > 0) done = 1;
      else begin
        @(posedge clk); @(negedge clk);
        switch_d = 1'b0;
      end
    end
    @(negedge clk);
    compared++;
    if (n !== 162) begin mismatched++; $display("FAIL def_reads: got %0d expected 162", n); end
    compared++;
    if (nlast !== 1 || last_a !== 8'd49) begin
      mismatched++; $display("FAIL def_last: got count %0d addr %0d expected count 1 addr 49", nlast, last_a);
    end
    compared++;
    if (rts_d !== 1'b1 || out_valid_d !== 1'b0) begin
      mismatched++; $display("FAIL def_end: got rts=%b ov=%b expected rts=1 ov=0", rts_d, out_valid_d);
    end
  endtask

  task automatic test_rst_mid();
    sb_start();
    cyc_s(1'b1, 1'b1);
    for (int i = 0; i < 20 && n_ren < 7; i++) cyc_s(1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({ren_s, out_valid_s, rts_s, err_s} !== 4'b0010) begin
      mismatched++; $display("FAIL rst_mid: got ren/ov/rts/err=%b%b%b%b expected 0010", ren_s, out_valid_s, rts_s, err_s);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    sb_start();
    cyc_s(1'b1, 1'b1);
    for (int i = 0; i < 60 && rise < 0; i++) cyc_s(1'b0, 1'b1);
    check_bank_end("restart");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_switch_err();
    test_default_params();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
